// File: rtl/ecc_decode_sel.sv
// ECC correction selector: applies the highest-priority usable error pattern to each raw
// PROM word, registers the result one cycle later and keeps corrected/undecodable statistics.
module ecc_decode_sel #(
  parameter int DW   = 12,
  parameter int PW   = 12,
  parameter int NSRC = 4,
  parameter int CW   = 16,
  localparam int SW  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     ECC_EN,
  input  logic                     CLR_CNT,
  input  logic                     IN_VLD,
  input  logic [DW-1:0]            RD,
  input  logic [PW-1:0]            RP,
  input  logic [NSRC-1:0]          SRC_USE,
  input  logic [NSRC*(DW+PW)-1:0]  SRC_ERR,
  output logic [DW-1:0]            DOUT,
  output logic [PW-1:0]            POUT,
  output logic                     OUT_STB,
  output logic                     VALID,
  output logic                     CORUPT,
  output logic [SW-1:0]            SRC_SEL,
  output logic [CW-1:0]            WORD_CNT,
  output logic [CW-1:0]            COR_CNT,
  output logic [CW-1:0]            UNC_CNT,
  output logic                     UNC_FLAG,
  output logic [CW-1:0]            FIRST_UNC
);

  localparam int EW = DW + PW;

  logic [EW-1:0] sel_err;
  logic [SW-1:0] sel_idx;
  logic          sel_found;

  logic [DW-1:0] dec_dout;
  logic [PW-1:0] dec_pout;
  logic          dec_valid;
  logic          dec_corupt;
  logic [SW-1:0] dec_sel;

  logic [DW-1:0] dout_q, dout_d;
  logic [PW-1:0] pout_q, pout_d;
  logic          valid_q, valid_d;
  logic          corupt_q, corupt_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          stb_q, stb_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic [CW-1:0] cor_cnt_q, cor_cnt_d;
  logic [CW-1:0] unc_cnt_q, unc_cnt_d;
  logic          unc_flag_q, unc_flag_d;
  logic [CW-1:0] first_unc_q, first_unc_d;

  // Scan from lowest priority upward so the last hit (lowest index) wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_err   = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (SRC_USE[i]) begin
        sel_found = 1'b1;
        sel_idx   = SW'(i);
        sel_err   = SRC_ERR[i*EW +: EW];
      end
    end
  end

  always_comb begin
    dec_dout   = RD;
    dec_pout   = RP;
    dec_valid  = 1'b1;
    dec_corupt = 1'b0;
    dec_sel    = '0;
    if (ECC_EN) begin
      if (sel_found) begin
        dec_dout   = RD ^ sel_err[EW-1:PW];
        dec_pout   = RP ^ sel_err[PW-1:0];
        dec_corupt = |sel_err;
        dec_sel    = sel_idx;
      end else begin
        dec_valid  = 1'b0;
        dec_corupt = 1'b1;
      end
    end
  end

  always_comb begin
    dout_d      = dout_q;
    pout_d      = pout_q;
    valid_d     = valid_q;
    corupt_d    = corupt_q;
    sel_d       = sel_q;
    stb_d       = IN_VLD;
    word_cnt_d  = word_cnt_q;
    cor_cnt_d   = cor_cnt_q;
    unc_cnt_d   = unc_cnt_q;
    unc_flag_d  = unc_flag_q;
    first_unc_d = first_unc_q;

    if (IN_VLD) begin
      dout_d   = dec_dout;
      pout_d   = dec_pout;
      valid_d  = dec_valid;
      corupt_d = dec_corupt;
      sel_d    = dec_sel;
    end

    // A clear wins over the word arriving in the same cycle; that word is not counted.
    if (CLR_CNT) begin
      word_cnt_d  = '0;
      cor_cnt_d   = '0;
      unc_cnt_d   = '0;
      unc_flag_d  = 1'b0;
      first_unc_d = '0;
    end else if (IN_VLD) begin
      if (!(&word_cnt_q)) word_cnt_d = word_cnt_q + CW'(1);
      if (dec_valid && dec_corupt && !(&cor_cnt_q)) cor_cnt_d = cor_cnt_q + CW'(1);
      if (!dec_valid && !(&unc_cnt_q)) unc_cnt_d = unc_cnt_q + CW'(1);
      if (!dec_valid && !unc_flag_q) begin
        unc_flag_d  = 1'b1;
        first_unc_d = word_cnt_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dout_q      <= '0;
      pout_q      <= '0;
      valid_q     <= 1'b0;
      corupt_q    <= 1'b0;
      sel_q       <= '0;
      stb_q       <= 1'b0;
      word_cnt_q  <= '0;
      cor_cnt_q   <= '0;
      unc_cnt_q   <= '0;
      unc_flag_q  <= 1'b0;
      first_unc_q <= '0;
    end else begin
      dout_q      <= dout_d;
      pout_q      <= pout_d;
      valid_q     <= valid_d;
      corupt_q    <= corupt_d;
      sel_q       <= sel_d;
      stb_q       <= stb_d;
      word_cnt_q  <= word_cnt_d;
      cor_cnt_q   <= cor_cnt_d;
      unc_cnt_q   <= unc_cnt_d;
      unc_flag_q  <= unc_flag_d;
      first_unc_q <= first_unc_d;
    end
  end

  assign DOUT      = dout_q;
  assign POUT      = pout_q;
  assign VALID     = valid_q;
  assign CORUPT    = corupt_q;
  assign SRC_SEL   = sel_q;
  assign OUT_STB   = stb_q;
  assign WORD_CNT  = word_cnt_q;
  assign COR_CNT   = cor_cnt_q;
  assign UNC_CNT   = unc_cnt_q;
  assign UNC_FLAG  = unc_flag_q;
  assign FIRST_UNC = first_unc_q;

endmodule

// File: tb/tb_ecc_decode_sel.sv
// Bench for ecc_decode_sel: directed plan vectors plus random words against a behavioural model.
module tb_ecc_decode_sel;

  logic        CLK = 1'b0;
  logic        RST_N, ECC_EN, CLR_CNT, IN_VLD;
  logic [11:0] RD, RP;
  logic [3:0]  SRC_USE;
  logic [95:0] SRC_ERR;
  logic [11:0] DOUT, POUT;
  logic        OUT_STB, VALID, CORUPT, UNC_FLAG;
  logic [1:0]  SRC_SEL;
  logic [15:0] WORD_CNT, COR_CNT, UNC_CNT, FIRST_UNC;

  int checks = 0;
  int failures = 0;

  // Model state
  logic [11:0] e_dout, e_pout;
  logic        e_valid, e_corupt, e_stb, e_flag;
  logic [1:0]  e_sel;
  int          e_word, e_cor, e_unc, e_first;

  ecc_decode_sel #(.DW(12), .PW(12), .NSRC(4), .CW(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .ECC_EN(ECC_EN), .CLR_CNT(CLR_CNT), .IN_VLD(IN_VLD),
    .RD(RD), .RP(RP), .SRC_USE(SRC_USE), .SRC_ERR(SRC_ERR),
    .DOUT(DOUT), .POUT(POUT), .OUT_STB(OUT_STB), .VALID(VALID), .CORUPT(CORUPT),
    .SRC_SEL(SRC_SEL), .WORD_CNT(WORD_CNT), .COR_CNT(COR_CNT), .UNC_CNT(UNC_CNT),
    .UNC_FLAG(UNC_FLAG), .FIRST_UNC(FIRST_UNC)
  );

  always #5 CLK = ~CLK;

  function automatic logic [28:0] dut_out();
    return {DOUT, POUT, VALID, CORUPT, SRC_SEL, OUT_STB};
  endfunction
  function automatic logic [28:0] exp_out();
    return {e_dout, e_pout, e_valid, e_corupt, e_sel, e_stb};
  endfunction
  function automatic logic [64:0] dut_cnt();
    return {WORD_CNT, COR_CNT, UNC_CNT, FIRST_UNC, UNC_FLAG};
  endfunction
  function automatic logic [64:0] exp_cnt();
    return {16'(e_word), 16'(e_cor), 16'(e_unc), 16'(e_first), e_flag};
  endfunction

  task automatic model_reset();
    e_dout = '0; e_pout = '0; e_valid = 0; e_corupt = 0; e_sel = '0; e_stb = 0;
    e_word = 0; e_cor = 0; e_unc = 0; e_first = 0; e_flag = 0;
  endtask

  // Spec-level model: what the registered outputs must be after the next edge.
  task automatic model_step();
    int k;
    logic [23:0] err;
    e_stb = IN_VLD;
    if (IN_VLD) begin
      e_dout = RD; e_pout = RP; e_sel = 0;
      if (!ECC_EN) begin
        e_valid = 1; e_corupt = 0;
      end else begin
        k = -1;
        for (int i = 0; i < 4; i++) if (SRC_USE[i] && k < 0) k = i;
        if (k < 0) begin
          e_valid = 0; e_corupt = 1;
        end else begin
          err = SRC_ERR[k*24 +: 24];
          e_dout = RD ^ err[23:12];
          e_pout = RP ^ err[11:0];
          e_valid = 1;
          e_corupt = (err != 0);
          e_sel = 2'(k);
        end
      end
    end
    if (CLR_CNT) begin
      e_word = 0; e_cor = 0; e_unc = 0; e_first = 0; e_flag = 0;
    end else if (IN_VLD) begin
      if (!e_valid && !e_flag) begin e_flag = 1; e_first = e_word; end
      if (e_word < 65535) e_word++;
      if (e_valid && e_corupt && e_cor < 65535) e_cor++;
      if (!e_valid && e_unc < 65535) e_unc++;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ECC_EN = 1; CLR_CNT = 0; IN_VLD = 0; RD = '0; RP = '0; SRC_USE = '0; SRC_ERR = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST_N = 0;
    model_reset();
    @(posedge CLK); @(posedge CLK); #1;
    checks++;
    if ({dut_out(), dut_cnt()} !== '0) begin
      failures++; $display("FAIL reset_state got=%h/%h want=0", dut_out(), dut_cnt());
    end
    RST_N = 1;
    cycle();
    checks++;
    if (OUT_STB !== 1'b0) begin failures++; $display("FAIL reset_idle_stb got=%b want=0", OUT_STB); end
  endtask

  task automatic test_priority();
    IN_VLD = 1; ECC_EN = 1; RD = 12'hABC; RP = 12'h123; SRC_USE = 4'b0110;
    SRC_ERR = '0;
    SRC_ERR[24 +: 24] = {12'h001, 12'h000};
    SRC_ERR[48 +: 24] = {12'hFFF, 12'hFFF};
    SRC_ERR[0 +: 24]  = {12'h0F0, 12'h00F};
    cycle();
    checks++;
    if (dut_out() !== {12'hABD, 12'h123, 1'b1, 1'b1, 2'd1, 1'b1}) begin
      failures++; $display("FAIL priority_out got=%h want=%h", dut_out(), {12'hABD, 12'h123, 1'b1, 1'b1, 2'd1, 1'b1});
    end
    checks++;
    if (COR_CNT !== 16'd1 || WORD_CNT !== 16'd1) begin
      failures++; $display("FAIL priority_cnt got cor=%0d word=%0d want cor=1 word=1", COR_CNT, WORD_CNT);
    end
    IN_VLD = 0; RD = 12'h000; SRC_USE = 4'b0001;
    cycle();
    checks++;
    if (dut_out() !== exp_out()) begin
      failures++; $display("FAIL hold_out got=%h want=%h", dut_out(), exp_out());
    end
  endtask

  task automatic test_clean();
    for (int n = 0; n < 4; n++) begin
      IN_VLD = 1; RD = 12'($urandom); RP = 12'($urandom); SRC_USE = 4'b0001 | 4'($urandom);
      SRC_ERR = {$urandom, $urandom, $urandom};
      SRC_ERR[0 +: 24] = '0;
      cycle();
      checks++;
      if (dut_out() !== exp_out() || VALID !== 1'b1 || CORUPT !== 1'b0) begin
        failures++; $display("FAIL clean_out got=%h want=%h", dut_out(), exp_out());
      end
      checks++;
      if (dut_cnt() !== exp_cnt()) begin
        failures++; $display("FAIL clean_cnt got=%h want=%h", dut_cnt(), exp_cnt());
      end
    end
    IN_VLD = 0;
  endtask

  task automatic test_undecodable();
    CLR_CNT = 1; IN_VLD = 0;
    cycle();
    CLR_CNT = 0;
    for (int n = 0; n < 5; n++) begin
      IN_VLD = 1; RD = 12'($urandom); RP = 12'($urandom); SRC_ERR = {$urandom, $urandom, $urandom};
      SRC_USE = (n < 3) ? 4'b1000 : 4'b0000;
      cycle();
      checks++;
      if (dut_out() !== exp_out()) begin
        failures++; $display("FAIL unc_out[%0d] got=%h want=%h", n, dut_out(), exp_out());
      end
    end
    IN_VLD = 0;
    checks++;
    if (UNC_CNT !== 16'd2 || UNC_FLAG !== 1'b1 || FIRST_UNC !== 16'd3 || VALID !== 1'b0 || CORUPT !== 1'b1) begin
      failures++; $display("FAIL unc_stats got unc=%0d flag=%b first=%0d v=%b c=%b want 2 1 3 0 1",
                           UNC_CNT, UNC_FLAG, FIRST_UNC, VALID, CORUPT);
    end
    checks++;
    if (dut_cnt() !== exp_cnt()) begin
      failures++; $display("FAIL unc_cnt got=%h want=%h", dut_cnt(), exp_cnt());
    end
  endtask

  task automatic test_bypass();
    logic [15:0] cor0, unc0;
    cor0 = COR_CNT; unc0 = UNC_CNT;
    IN_VLD = 1; ECC_EN = 0; RD = 12'h555; RP = 12'h2A2; SRC_USE = 4'b1111;
    SRC_ERR = {24'h111111, 24'h222222, 24'h333333, 24'h444444};
    cycle();
    checks++;
    if (dut_out() !== {12'h555, 12'h2A2, 1'b1, 1'b0, 2'd0, 1'b1}) begin
      failures++; $display("FAIL bypass_out got=%h want=%h", dut_out(), {12'h555, 12'h2A2, 1'b1, 1'b0, 2'd0, 1'b1});
    end
    SRC_USE = 4'b0000;
    cycle();
    checks++;
    if (COR_CNT !== cor0 || UNC_CNT !== unc0 || VALID !== 1'b1 || dut_cnt() !== exp_cnt()) begin
      failures++; $display("FAIL bypass_cnt got cor=%0d unc=%0d v=%b want cor=%0d unc=%0d v=1",
                           COR_CNT, UNC_CNT, VALID, cor0, unc0);
    end
    ECC_EN = 1; IN_VLD = 0;
  endtask

  task automatic test_clear_vs_event();
    IN_VLD = 1; ECC_EN = 1; CLR_CNT = 1; SRC_USE = 4'b0000; RD = 12'h3C3; RP = 12'h0F0;
    cycle();
    checks++;
    if (VALID !== 1'b0 || OUT_STB !== 1'b1 || dut_cnt() !== '0) begin
      failures++; $display("FAIL clear_vs_event got v=%b stb=%b cnt=%h want v=0 stb=1 cnt=0", VALID, OUT_STB, dut_cnt());
    end
    CLR_CNT = 0; IN_VLD = 0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      IN_VLD = ($urandom_range(0, 3) != 0);
      ECC_EN = ($urandom_range(0, 4) != 0);
      CLR_CNT = ($urandom_range(0, 40) == 0);
      RD = 12'($urandom); RP = 12'($urandom);
      SRC_USE = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom);
      SRC_ERR = {$urandom, $urandom, $urandom};
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 3) == 0) SRC_ERR[i*24 +: 24] = '0;
      cycle();
      checks++;
      if (dut_out() !== exp_out() || dut_cnt() !== exp_cnt()) begin
        failures++; $display("FAIL random[%0d] got=%h/%h want=%h/%h", n, dut_out(), dut_cnt(), exp_out(), exp_cnt());
      end
    end
    IN_VLD = 0; CLR_CNT = 0; ECC_EN = 1;
  endtask

  task automatic test_saturation_reset();
    CLR_CNT = 1; IN_VLD = 0;
    cycle();
    CLR_CNT = 0;
    IN_VLD = 1; ECC_EN = 1; RD = 12'h0AA; RP = 12'h055; SRC_USE = 4'b0001; SRC_ERR = 96'h1;
    for (int n = 0; n < 65540; n++) cycle();
    checks++;
    if (COR_CNT !== 16'hFFFF || WORD_CNT !== 16'hFFFF || dut_cnt() !== exp_cnt()) begin
      failures++; $display("FAIL saturate got cor=%h word=%h want FFFF FFFF", COR_CNT, WORD_CNT);
    end
    SRC_USE = 4'b0000;
    cycle();
    checks++;
    if (FIRST_UNC !== 16'hFFFF || UNC_FLAG !== 1'b1 || WORD_CNT !== 16'hFFFF || dut_cnt() !== exp_cnt()) begin
      failures++; $display("FAIL sat_capture got first=%h flag=%b word=%h want FFFF 1 FFFF", FIRST_UNC, UNC_FLAG, WORD_CNT);
    end
    SRC_USE = 4'b0001;
    #2;
    RST_N = 0;
    model_reset();
    #1;
    checks++;
    if ({dut_out(), dut_cnt()} !== '0) begin
      failures++; $display("FAIL midstream_reset got=%h/%h want=0", dut_out(), dut_cnt());
    end
    @(posedge CLK); #1;
    RST_N = 1; IN_VLD = 0;
    cycle();
    checks++;
    if ({dut_out(), dut_cnt()} !== '0) begin
      failures++; $display("FAIL post_reset_idle got=%h/%h want=0", dut_out(), dut_cnt());
    end
    IN_VLD = 1;
    cycle();
    checks++;
    if (OUT_STB !== 1'b1 || WORD_CNT !== 16'd1 || dut_out() !== exp_out() || dut_cnt() !== exp_cnt()) begin
      failures++; $display("FAIL post_reset_word got stb=%b word=%0d out=%h want stb=1 word=1 out=%h",
                           OUT_STB, WORD_CNT, dut_out(), exp_out());
    end
    IN_VLD = 0;
    cycle();
    checks++;
    if (OUT_STB !== 1'b0) begin failures++; $display("FAIL post_reset_stb_pulse got=%b want=0", OUT_STB); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_clean();
    test_undecodable();
    test_bypass();
    test_clear_vs_event();
    test_random();
    test_saturation_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ecc_decode_sel.md
Name: ecc_decode_sel

Overview:
- Parametrised ECC correction selector and error accountant for the PROM readback path.
- Takes one raw data/parity word per strobe plus NSRC candidate error patterns from parallel syndrome decoders (plain syndrome, inverted-syndrome, bit-swap variants, ...).
- Applies the highest-priority usable pattern, registers the corrected word, and tracks corrected/uncorrectable statistics.
- The PROM readout controller reads these statistics after a load.

Parameters:
- DW, 12, data word width.
- PW, 12, parity word width.
- NSRC, 4, number of candidate correction sources; index 0 has highest priority.
- CW, 16, width of word, corrected and uncorrectable counters.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- ECC_EN  in  1  1 = apply correction; 0 = bypass mode.
- CLR_CNT  in  1  synchronous clear of counters and first-error capture.
- IN_VLD  in  1  RD/RP/SRC_* are valid this cycle.
- RD  in  DW  raw data word.
- RP  in  PW  raw parity word.
- SRC_USE  in  NSRC  per-source "pattern is usable" flags.
- SRC_ERR  in  NSRC*(DW+PW)  flattened error patterns. Source i occupies bits [(i+1)*(DW+PW)-1 : i*(DW+PW)]; within a slice, the upper DW bits are the data error and the lower PW bits are the parity error.
- DOUT  out  DW  corrected data.
- POUT  out  PW  corrected parity.
- OUT_STB  out  1  DOUT/POUT/VALID/CORUPT/SRC_SEL updated this cycle.
- VALID  out  1  word decodable (some source usable, or bypass).
- CORUPT  out  1  word had a nonzero error, or was undecodable.
- SRC_SEL  out  clog2(NSRC) (min 1)  index of the applied source; 0 when none.
- WORD_CNT  out  CW  words accepted since clear.
- COR_CNT  out  CW  words corrected (VALID=1, CORUPT=1).
- UNC_CNT  out  CW  undecodable words (VALID=0).
- UNC_FLAG  out  1  sticky: at least one undecodable word since clear.
- FIRST_UNC  out  CW  WORD_CNT value of the first undecodable word since clear.

Behaviour:
- Reset (RST_N=0, asynchronous): every output is 0.
- Latency: exactly 1 cycle.
  - OUT_STB is IN_VLD registered.
  - Data outputs update only on cycles with IN_VLD=1 and hold otherwise.
- Source selection, when IN_VLD=1 and ECC_EN=1:
  - k = lowest index with SRC_USE[k]=1.
  - If k exists: DOUT=RD^ERRk[data], POUT=RP^ERRk[parity], VALID=1, CORUPT=|ERRk (OR-reduction of ERRk), SRC_SEL=k.
  - If no SRC_USE bit is set: DOUT=RD, POUT=RP, VALID=0, CORUPT=1, SRC_SEL=0.
- Bypass, when ECC_EN=0: DOUT=RD, POUT=RP, VALID=1, CORUPT=0, SRC_SEL=0. SRC_USE and SRC_ERR are ignored; no cor/unc counting.
- Patterns of lower-priority sources never affect outputs, even when they differ from the selected pattern.
- Counters: evaluated in the same registered cycle as the output, for each IN_VLD=1 word.
  - WORD_CNT += 1.
  - COR_CNT += 1 when the produced word has VALID=1 and CORUPT=1.
  - UNC_CNT += 1 when VALID=0.
  - All three saturate at 2^CW-1; no wrap.
  - The address recorded in FIRST_UNC is the WORD_CNT value before increment, i.e. the 0-based word index.
- First-error capture: on an undecodable word while UNC_FLAG=0, FIRST_UNC takes that word's index and UNC_FLAG is set to 1. Later undecodable words do not change FIRST_UNC. If WORD_CNT is saturated, the saturated value is captured.
- CLR_CNT=1 (synchronous):
  - WORD_CNT, COR_CNT, UNC_CNT, FIRST_UNC and UNC_FLAG go to 0 next cycle.
  - Clear takes priority over a simultaneous IN_VLD word: that word is decoded and output normally but not counted or captured.
  - DOUT/POUT/VALID/CORUPT/SRC_SEL/OUT_STB are not affected by CLR_CNT.
- Reset asserted mid-stream: all outputs go to 0 immediately. After release, the first IN_VLD word appears with OUT_STB one cycle later. No partial state survives.
- ECC_EN may change on any cycle. It is sampled together with IN_VLD, so there is no pipeline mixing.

Test Plan (DW=PW=12, NSRC=4, CW=16):
- Priority: IN_VLD=1, RD=0xABC, RP=0x123, SRC_USE=4'b0110, ERR1={0x001,0x000}, ERR2={0xFFF,0xFFF} -> next cycle OUT_STB=1, DOUT=0xABD, POUT=0x123, VALID=1, CORUPT=1, SRC_SEL=1, COR_CNT=1.
- Clean word: SRC_USE=4'b0001, ERR0=0 -> DOUT=RD, POUT=RP, VALID=1, CORUPT=0, COR_CNT unchanged, WORD_CNT increments.
- Undecodable: three clean words, then SRC_USE=0 on word index 3, then a second SRC_USE=0 word -> VALID=0, CORUPT=1; UNC_CNT=2, UNC_FLAG=1, FIRST_UNC=3.
- Bypass: ECC_EN=0, SRC_USE=4'b1111 with nonzero patterns, RD=0x555 -> DOUT=0x555, VALID=1, CORUPT=0; COR_CNT and UNC_CNT unchanged.
- Clear vs. event: CLR_CNT=1 together with an undecodable IN_VLD word -> next cycle VALID=0 and OUT_STB=1, but all counters=0 and UNC_FLAG=0.
- Saturation and reset: preload via 65540 corrected words -> COR_CNT=0xFFFF, WORD_CNT=0xFFFF. Then RST_N low mid-stream -> all outputs 0 immediately. After release, one IN_VLD word -> OUT_STB pulses one cycle later.
